// File: rtl/key_handle_multi.sv
// rtl/key_handle_multi.sv - multi-channel key synchroniser, debouncer and edge/auto-repeat pulse generator
// Optional auto-repeat on held keys: define KEY_REPEAT_EN.
module key_handle_multi #(
  parameter int KEY_NUM   = 4,
  parameter int DEB_CNT   = 3,
  parameter int EDGE_MODE = 0,
  parameter int REP_DLY   = 125,
  parameter int REP_PER   = 25
) (
  input  logic               clk,
  input  logic               rst_sync,
  input  logic               tick,
  input  logic [KEY_NUM-1:0] key,
  output logic [KEY_NUM-1:0] key_pulse,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_rep
);

  localparam int MAX_A = (DEB_CNT > REP_DLY) ? DEB_CNT : REP_DLY;
  localparam int MAX_C = (MAX_A > REP_PER) ? MAX_A : REP_PER;
  localparam int CNT_W = $clog2(MAX_C + 1);
  localparam logic [CNT_W-1:0] DEB_C = CNT_W'(DEB_CNT);

  typedef enum logic [1:0] {RELEASED, PRESS_DEB, PRESSED, REL_DEB} state_t;

  logic [KEY_NUM-1:0] sync1, sync2;

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
    logic             s, enter_press, enter_release, pulse_q, level_q;

    assign s       = sync2[i];
    assign cnt_inc = cnt + 1'b1;

    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (tick) begin
        case (state)
          RELEASED: if (!s) begin
            state_nx = (DEB_CNT == 1) ? PRESSED : PRESS_DEB;
            cnt_nx   = (DEB_CNT == 1) ? '0 : CNT_W'(1);
          end
          PRESS_DEB: begin
            if (s) begin
              state_nx = RELEASED;
              cnt_nx   = '0;
            end else if (cnt_inc == DEB_C) begin
              state_nx = PRESSED;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt_inc;
            end
          end
          PRESSED: if (s) begin
            state_nx = (DEB_CNT == 1) ? RELEASED : REL_DEB;
            cnt_nx   = (DEB_CNT == 1) ? '0 : CNT_W'(1);
          end
          REL_DEB: begin
            if (!s) begin
              state_nx = PRESSED;
              cnt_nx   = '0;
            end else if (cnt_inc == DEB_C) begin
              state_nx = RELEASED;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt_inc;
            end
          end
          default: begin
            state_nx = RELEASED;
            cnt_nx   = '0;
          end
        endcase
      end
    end

    // A bounce back from REL_DEB to PRESSED is not a new press.
    assign enter_press   = (state == RELEASED || state == PRESS_DEB) && state_nx == PRESSED;
    assign enter_release = (state == PRESSED || state == REL_DEB) && state_nx == RELEASED;

    always_ff @(posedge clk) begin
      if (rst_sync) begin
        state   <= RELEASED;
        cnt     <= '0;
        pulse_q <= 1'b0;
        level_q <= 1'b0;
      end else begin
        state   <= state_nx;
        cnt     <= cnt_nx;
        pulse_q <= (EDGE_MODE != 0) ? enter_press : enter_release;
        level_q <= (state_nx == PRESSED || state_nx == REL_DEB);
      end
    end

    assign key_pulse[i] = pulse_q;
    assign key_state[i] = level_q;

`ifdef KEY_REPEAT_EN
    logic [CNT_W-1:0] rcnt, rcnt_inc, rlim;
    logic             rep_on, rep_q;

    assign rcnt_inc = rcnt + 1'b1;
    assign rlim     = rep_on ? CNT_W'(REP_PER) : CNT_W'(REP_DLY);

    // Only ticks that keep the key in PRESSED count; REL_DEB holds the count.
    always_ff @(posedge clk) begin
      if (rst_sync) begin
        rcnt   <= '0;
        rep_on <= 1'b0;
        rep_q  <= 1'b0;
      end else begin
        rep_q <= 1'b0;
        if (enter_press || state_nx == RELEASED) begin
          rcnt   <= '0;
          rep_on <= 1'b0;
        end else if (tick && state == PRESSED && state_nx == PRESSED) begin
          if (rcnt_inc == rlim) begin
            rcnt   <= '0;
            rep_on <= 1'b1;
            rep_q  <= 1'b1;
          end else begin
            rcnt <= rcnt_inc;
          end
        end
      end
    end

    assign key_rep[i] = rep_q;
`else
    assign key_rep[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_key_handle_multi.sv
// tb/tb_key_handle_multi.sv - scoreboard bench for key_handle_multi, release- and press-edge instances
module tb_key_handle_multi;
`ifdef KEY_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_sync, tick;
  logic [3:0] key;
  logic [3:0] p0, s0, r0, p1, s1, r1;
  int         cyc = 0;
  int         checks = 0, errors = 0;

  typedef struct {
    int         cyc;
    logic [3:0] p0, p1, rep;
  } ev_t;
  ev_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_handle_multi #(.KEY_NUM(4), .DEB_CNT(3), .EDGE_MODE(0), .REP_DLY(4), .REP_PER(2)) u_rel (
    .clk(clk), .rst_sync(rst_sync), .tick(tick), .key(key),
    .key_pulse(p0), .key_state(s0), .key_rep(r0));

  key_handle_multi #(.KEY_NUM(4), .DEB_CNT(3), .EDGE_MODE(1), .REP_DLY(4), .REP_PER(2)) u_prs (
    .clk(clk), .rst_sync(rst_sync), .tick(tick), .key(key),
    .key_pulse(p1), .key_state(s1), .key_rep(r1));

  always @(negedge clk) begin
    ev_t e;
    if ((p0 | p1 | r0 | r1) != 4'b0) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d got p0=%b p1=%b rep0=%b rep1=%b expected no pulse",
                 cyc, p0, p1, r0, r1);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.p0 != p0 || e.p1 != p1 || e.rep != r0 || e.rep != r1) begin
          errors++;
          $display("FAIL pulse_event got cyc=%0d p0=%b p1=%b rep0=%b rep1=%b expected cyc=%0d p0=%b p1=%b rep=%b",
                   cyc, p0, p1, r0, r1, e.cyc, e.p0, e.p1, e.rep);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string name, input logic [3:0] exp);
    chk({name, "_rel"}, {8'h0, s0}, {8'h0, exp});
    chk({name, "_prs"}, {8'h0, s1}, {8'h0, exp});
  endtask

  task automatic set_key(input logic [3:0] v);
    @(negedge clk);
    key = v;
    @(negedge clk);
  endtask

  task automatic tick_once(input logic [3:0] ep0, input logic [3:0] ep1, input logic [3:0] erep);
    ev_t e;
    @(negedge clk);
    if ((ep0 | ep1 | erep) != 4'b0) begin
      e.cyc = cyc + 1;
      e.p0  = ep0;
      e.p1  = ep1;
      e.rep = erep;
      q.push_back(e);
    end
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick_once(4'h0, 4'h0, 4'h0);
  endtask

  initial begin
    rst_sync = 1'b1;
    tick     = 1'b0;
    key      = 4'hF;

    // reset state, then a key held low during reset must not register
    repeat (5) @(negedge clk);
    chk("reset_rel", {p0, s0, r0}, 12'h000);
    chk("reset_prs", {p1, s1, r1}, 12'h000);
    set_key(4'hE);
    ticks(4);
    chk("reset_hold_rel", {p0, s0, r0}, 12'h000);
    chk("reset_hold_prs", {p1, s1, r1}, 12'h000);
    set_key(4'hF);
    @(negedge clk);
    rst_sync = 1'b0;

    // key[1] press/release with DEB_CNT=3
    set_key(4'b1101);
    ticks(2);
    chk_state("press_pending", 4'b0000);
    tick_once(4'h0, 4'b0010, 4'h0);
    chk_state("press_accepted", 4'b0010);
    ticks(2);
    set_key(4'hF);
    ticks(2);
    chk_state("release_pending", 4'b0010);
    tick_once(4'b0010, 4'h0, 4'h0);
    chk_state("release_accepted", 4'b0000);

    // key[2] bounce rejected
    set_key(4'b1011);
    ticks(2);
    set_key(4'hF);
    ticks(3);
    chk_state("bounce", 4'b0000);

    // keys 0 and 3 pressed in the same cycle
    set_key(4'b0110);
    ticks(2);
    tick_once(4'h0, 4'b1001, 4'h0);
    chk_state("dual_press", 4'b1001);
    set_key(4'hF);
    ticks(2);
    tick_once(4'b1001, 4'h0, 4'h0);
    chk_state("dual_release", 4'b0000);

    // reset during release debounce discards progress
    set_key(4'b0111);
    ticks(2);
    tick_once(4'h0, 4'b1000, 4'h0);
    set_key(4'hF);
    ticks(1);
    chk_state("rel_deb_before_rst", 4'b1000);
    @(negedge clk);
    rst_sync = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_rel", {p0, s0, r0}, 12'h000);
    chk("mid_rst_prs", {p1, s1, r1}, 12'h000);
    rst_sync = 1'b0;
    ticks(4);
    chk_state("after_mid_rst", 4'b0000);

    // key[0] held 10 ticks in PRESSED: repeats after ticks 4,6,8,10 when enabled
    set_key(4'b1110);
    ticks(2);
    tick_once(4'h0, 4'b0001, 4'h0);
    for (int k = 1; k <= 10; k++)
      tick_once(4'h0, 4'h0, (REP && k >= 4 && k % 2 == 0) ? 4'b0001 : 4'b0000);
    chk_state("repeat_held", 4'b0001);
    set_key(4'hF);
    ticks(2);
    tick_once(4'b0001, 4'h0, 4'h0);
    chk_state("repeat_release", 4'b0000);

    repeat (4) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses got %0d outstanding expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
